sort_stream_engine: RTL
=======================

SORT_STREAM_ENGINE -- requirements
Module: sort_stream_engine

Interface
REQ-001 SHALL have parameter N, default 5, number of elements per batch (N >= 2).
REQ-002 SHALL have parameter W, default 8, element width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset: 0 = asserted, 1 = run.
REQ-005 SHALL have port in_valid, input, 1, upstream element valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts an element this cycle.
REQ-007 SHALL have port in_data, input, W, unsorted element.
REQ-008 SHALL have port out_valid, output, 1, a sorted element is presented.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the element.
REQ-010 SHALL have port out_data, output, W, sorted element, ascending order.
REQ-011 SHALL have port out_index, output, $clog2(N), original arrival position (0..N-1) of out_data.
REQ-012 SHALL have port busy, output, 1, high in SORT or DRAIN.

Function
REQ-013 SHALL implement a three-state FSM: LOAD, SORT, DRAIN.
REQ-014 LOAD: in_ready=1, out_valid=0, busy=0; an element is accepted on an edge with in_valid&in_ready, stored in slot[cnt] with tag cnt, and cnt increments.
REQ-015 LOAD -> SORT on the edge accepting element N-1; cnt cleared, phase counter p cleared.
REQ-016 SORT: in_ready=0, out_valid=0, busy=1; each edge performs one odd-even transposition phase, then p increments.
REQ-017 Even p: compare-swap pairs (0,1),(2,3),...; odd p: pairs (1,2),(3,4),...; an unpaired end slot holds.
REQ-018 Compare-swap SHALL exchange value and tag only if slot[i] > slot[i+1] (unsigned, strict), so equal values keep arrival order.
REQ-019 SORT -> DRAIN on the edge performing phase N-1: exactly N SORT cycles, first out_valid exactly N cycles after the last input accept.
REQ-020 DRAIN: out_valid=1, in_ready=0, busy=1; out_data/out_index = slot[k]/tag[k], k starting at 0.
REQ-021 On an edge with out_valid&out_ready, k increments; after element N-1 transfers, -> LOAD with k=0, so in_ready is 1 the following cycle.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_index SHALL hold stable.
REQ-023 in_valid during SORT/DRAIN, and out_ready outside DRAIN, SHALL be ignored with no state change.
REQ-024 No overlap between batches; gaps in in_valid in LOAD SHALL only stall cnt.
REQ-025 Out_index SHALL be a permutation of 0..N-1 within each batch.

Reset
REQ-026 Reset assertion SHALL immediately force state=LOAD, cnt=p=k=0, all slots and tags = 0, regardless of clock.
REQ-027 While reset=0: in_ready=0, out_valid=0, busy=0, out_data=0, out_index=0.
REQ-028 First rising edge after reset release SHALL see in_ready=1.
REQ-029 Reset mid-LOAD, mid-SORT, or mid-DRAIN SHALL discard the partial batch; the next batch SHALL start at slot 0.

Verification
REQ-030 Basic: inputs 9,3,7,1,5 with out_ready=1 -> (data,index) = (1,3),(3,1),(5,4),(7,2),(9,0); first out_valid 5 cycles after the 5th accept.
REQ-031 Order extremes: 1,2,3,4,5 -> indices 0..4 in order; 5,4,3,2,1 -> data 1..5, indices 4,3,2,1,0.
REQ-032 Ties and range: 4,2,4,2,0 -> (0,4),(2,1),(2,3),(4,0),(4,2); 255,0,255,0,128 -> 0,0,128,255,255 with indices 1,3,4,0,2.
REQ-033 Backpressure: random out_ready and in_valid gaps -> outputs held stable while stalled; exactly 5 transfers; in_ready=0 until the last transfer.
REQ-034 Reset mid-SORT (phase 2) then batch 6,6,1,9,0 -> outputs (0,4),(1,2),(6,0),(6,1),(9,3) with no residue from the aborted batch.
REQ-035 Protocol: in_valid=1 held through SORT/DRAIN -> no extra accepts; back-to-back batches -> second batch accepted the cycle after the first DRAIN completes.

Source files
------------

// File: rtl/sort_stream_engine.sv
// -----------------------------------------------------------------------------
// sort_stream_engine
//
// Collects a batch of N unsigned elements, sorts them ascending with an
// odd-even transposition network (one phase per clock, N phases), then
// streams them out in order together with each element's original arrival
// position. Equal values keep their arrival order.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds data stable while valid is high and ready is
// low; ready never depends combinationally on valid on either side.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset      in   asynchronous active-low reset (0 = asserted)
//   in_valid   in   upstream element valid
//   in_ready   out  element accepted this cycle (LOAD only)
//   in_data    in   [W-1:0] unsorted element
//   out_valid  out  sorted element presented (DRAIN only)
//   out_ready  in   downstream accepts the element
//   out_data   out  [W-1:0] sorted element, ascending
//   out_index  out  [$clog2(N)-1:0] arrival position of out_data
//   busy       out  high while sorting or draining
//   fsm_state  out  [1:0] current FSM state (0 LOAD, 1 SORT, 2 DRAIN)
// -----------------------------------------------------------------------------
module sort_stream_engine #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 busy,
    output logic [1:0]           fsm_state
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] p_q, p_d;
    logic [IW-1:0] k_q, k_d;
    logic [W-1:0]  slot_q [N];
    logic [W-1:0]  slot_d [N];
    logic [IW-1:0] tag_q  [N];
    logic [IW-1:0] tag_d  [N];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        k_d       = k_q;
        slot_d    = slot_q;
        tag_d     = tag_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            LOAD: begin
                // Gated by reset so in_ready reads 0 while reset is held,
                // even though the state register already sits in LOAD.
                in_ready = reset;
                if (in_valid) begin
                    slot_d[cnt_q] = in_data;
                    tag_d[cnt_q]  = cnt_q;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        p_d     = '0;
                        state_d = SORT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            SORT: begin
                busy = 1'b1;
                // Pairs starting at an index with the same parity as p are
                // compared this phase. Pairs are disjoint, so every swap can
                // read the registered values directly.
                for (int i = 0; i < N - 1; i++) begin
                    if ((i[0] == p_q[0]) && (slot_q[i] > slot_q[i+1])) begin
                        slot_d[i]   = slot_q[i+1];
                        slot_d[i+1] = slot_q[i];
                        tag_d[i]    = tag_q[i+1];
                        tag_d[i+1]  = tag_q[i];
                    end
                end
                if (p_q == LAST) begin
                    p_d     = '0;
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end

            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (k_q == LAST) begin
                        k_d     = '0;
                        state_d = LOAD;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Outputs are driven from registers only, so they stay stable while
    // out_ready is low; zero outside DRAIN keeps idle/reset outputs clean.
    assign out_data  = (state_q == DRAIN) ? slot_q[k_q] : '0;
    assign out_index = (state_q == DRAIN) ? tag_q[k_q]  : '0;
    assign fsm_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            p_q     <= '0;
            k_q     <= '0;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            k_q     <= k_d;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= slot_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

endmodule
